// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-addressed memory port between the CPU and the IOP.
// IOP has priority; a streak limit lets a waiting CPU win after MAX_IOP_BURST IOP grants.
module memory_arbiter #(
  parameter int unsigned MAX_IOP_BURST = 4,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_write,
  input  logic [15:31] cpu_addr,
  input  logic [0:31]  cpu_wdata,
  output logic         cpu_done,
  output logic         cpu_fault,
  output logic [0:31]  cpu_rdata,
  input  logic         iop_req,
  input  logic         iop_write,
  input  logic [15:31] iop_addr,
  input  logic [0:31]  iop_wdata,
  output logic         iop_done,
  output logic         iop_fault,
  output logic [0:31]  iop_rdata,
  output logic         mem_req,
  output logic         mem_write,
  output logic [15:31] mem_address,
  output logic [0:31]  mem_wdata,
  input  logic [0:31]  mem_rdata,
  input  logic         mem_ack,
  output logic         busy,
  output logic         owner
);

  localparam int unsigned SW = 4;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;
  logic          grant_c;
  logic          grant_iop_c;
  logic          ack_c;
  logic          expire_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, winner selection and access termination
  always_comb begin
    state_nxt   = state;
    grant_c     = 1'b0;
    grant_iop_c = 1'b0;
    ack_c       = 1'b0;
    expire_c    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || iop_req) begin
          grant_c     = 1'b1;
          grant_iop_c = iop_req && !(cpu_req && (streak == SW'(MAX_IOP_BURST)));
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle takes precedence over the timeout.
        if (mem_ack) begin
          ack_c     = 1'b1;
          state_nxt = RESP;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          expire_c  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side request, ownership, streak and timeout bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      streak      <= '0;
      tmo_cnt     <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (grant_c) begin
        owner       <= grant_iop_c;
        mem_req     <= 1'b1;
        mem_write   <= grant_iop_c ? iop_write : cpu_write;
        mem_address <= grant_iop_c ? iop_addr  : cpu_addr;
        mem_wdata   <= grant_iop_c ? iop_wdata : cpu_wdata;
        tmo_cnt     <= '0;
        if (grant_iop_c && cpu_req) streak <= streak + SW'(1);
        else                        streak <= '0;
      end
      if (state == BUSY) begin
        if (ack_c || expire_c) mem_req <= 1'b0;
        else                   tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Requester-side completion pulses and read data
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_done  <= 1'b0;
      cpu_fault <= 1'b0;
      cpu_rdata <= '0;
      iop_done  <= 1'b0;
      iop_fault <= 1'b0;
      iop_rdata <= '0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_fault <= 1'b0;
      iop_done  <= 1'b0;
      iop_fault <= 1'b0;
      if (ack_c || expire_c) begin
        if (owner) begin
          iop_done  <= 1'b1;
          iop_fault <= expire_c;
        end else begin
          cpu_done  <= 1'b1;
          cpu_fault <= expire_c;
        end
      end
      if (ack_c && !mem_write) begin
        if (owner) iop_rdata <= mem_rdata;
        else       cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule
